// File: rtl/starflux_pkg.sv
// Shared constants and index-width helper for the starflux playfield blocks.
package starflux_pkg;

  localparam int unsigned ROWS_DEF     = 8;
  localparam int unsigned COLS_DEF     = 16;
  localparam int unsigned TICK_DIV_DEF = 50000000;
  localparam int unsigned COOLDOWN_DEF = 2;
  localparam int unsigned HIT_W_DEF    = 8;

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Advance-rate divider: down-counter producing a one-cycle tick every TICK_DIV cycles.
module tick_divider
  import starflux_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic clock,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned CNT_W = idx_w(TICK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d = cnt_q - CNT_W'(1);
    if (cnt_q == '0) cnt_d = CNT_W'(TICK_DIV - 1);
    tick_d = (cnt_d == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/projectile_grid.sv
// Projectile field: ROWS lanes of COLS-cell shift registers with shot loading,
// enemy hit detection, escape flagging and a registered lane read port.
module projectile_grid
  import starflux_pkg::*;
#(
  parameter  int unsigned ROWS     = ROWS_DEF,
  parameter  int unsigned COLS     = COLS_DEF,
  parameter  int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter  int unsigned COOLDOWN = COOLDOWN_DEF,
  parameter  int unsigned HIT_W    = HIT_W_DEF,
  localparam int unsigned RW       = idx_w(ROWS),
  localparam int unsigned CW       = idx_w(COLS)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             shoot,
  input  logic             wrap,
  input  logic [RW-1:0]    player_row,
  input  logic [RW-1:0]    enemy_row,
  input  logic [CW-1:0]    enemy_col,
  input  logic [RW-1:0]    rd_row,
  output logic [COLS-1:0]  rd_data,
  output logic             tick,
  output logic             hit,
  output logic             escaped,
  output logic [HIT_W-1:0] hit_count,
  output logic             active
);

  localparam int unsigned COOL_W = idx_w(COOLDOWN + 1);

  logic [ROWS-1:0][COLS-1:0] grid_q, grid_d;
  logic [COLS-1:0]           rd_data_q, rd_data_d;
  logic [HIT_W-1:0]          hit_count_q, hit_count_d;
  logic [RW-1:0]             pend_row_q, pend_row_d;
  logic [COOL_W-1:0]         cool_q, cool_d;
  logic                      pend_q, pend_d;
  logic                      shoot_q, shoot_d;
  logic                      hit_q, hit_d;
  logic                      escaped_q, escaped_d;
  logic                      active_q, active_d;

  logic                      shoot_edge, accept, load;
  logic [RW-1:0]             load_row;
  logic                      en_valid;
  logic [COLS-1:0]           en_mask;
  logic [ROWS-1:0]           hit_vec, last_col;

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_div (
    .clock   (clock),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // Shot acceptance: one pending slot, gated by cooldown and a legal lane.
  always_comb begin
    shoot_edge = shoot & ~shoot_q;
    accept     = shoot_edge && (cool_q == '0) && (32'(player_row) < ROWS) && !pend_q;
    load       = tick && (pend_q || accept);
    load_row   = pend_q ? pend_row_q : player_row;
    en_valid   = (32'(enemy_row) < ROWS) && (32'(enemy_col) < COLS);
    en_mask    = en_valid ? (COLS'(1) << enemy_col) : '0;
  end

  // Per-lane shift, column-0 injection and enemy-cell knockout.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [COLS-1:0] cur, shifted;
    logic            in_bit, hit_here;

    assign cur         = grid_q[r];
    assign in_bit      = (wrap & cur[COLS-1]) | (load & (load_row == RW'(r)));
    assign shifted     = tick ? {cur[COLS-2:0], in_bit} : cur;
    assign hit_here    = (enemy_row == RW'(r)) && (|(shifted & en_mask));
    assign hit_vec[r]  = hit_here;
    assign last_col[r] = cur[COLS-1];
    assign grid_d[r]   = clear ? '0 : (shifted & ~(hit_here ? en_mask : '0));
  end

  always_comb begin
    shoot_d     = shoot;
    pend_d      = pend_q;
    pend_row_d  = pend_row_q;
    cool_d      = cool_q;
    hit_d       = 1'b0;
    escaped_d   = 1'b0;
    hit_count_d = hit_count_q;
    active_d    = |grid_q;
    rd_data_d   = '0;

    if (32'(rd_row) < ROWS) rd_data_d = grid_q[rd_row];

    if (clear) begin
      pend_d      = 1'b0;
      cool_d      = '0;
      hit_count_d = '0;
    end else begin
      if (tick) begin
        pend_d = 1'b0;
        if (load) cool_d = COOL_W'(COOLDOWN);
        else if (cool_q != '0) cool_d = cool_q - COOL_W'(1);
        escaped_d = !wrap && (|last_col);
      end else if (accept) begin
        pend_d     = 1'b1;
        pend_row_d = player_row;
      end
      hit_d = |hit_vec;
      if (hit_d && (hit_count_q != '1)) hit_count_d = hit_count_q + HIT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grid_q      <= '0;
      rd_data_q   <= '0;
      hit_count_q <= '0;
      pend_row_q  <= '0;
      cool_q      <= '0;
      pend_q      <= 1'b0;
      shoot_q     <= 1'b0;
      hit_q       <= 1'b0;
      escaped_q   <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      grid_q      <= grid_d;
      rd_data_q   <= rd_data_d;
      hit_count_q <= hit_count_d;
      pend_row_q  <= pend_row_d;
      cool_q      <= cool_d;
      pend_q      <= pend_d;
      shoot_q     <= shoot_d;
      hit_q       <= hit_d;
      escaped_q   <= escaped_d;
      active_q    <= active_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign hit       = hit_q;
  assign escaped   = escaped_q;
  assign hit_count = hit_count_q;
  assign active    = active_q;

endmodule

// File: tb/tb_projectile_grid.sv
// Directed bench for projectile_grid with TICK_DIV=4, COOLDOWN=2, HIT_W=2.
module tb_projectile_grid;

  logic        clock, reset_n, clear, shoot, wrap;
  logic [2:0]  player_row, enemy_row, rd_row;
  logic [3:0]  enemy_col;
  logic [15:0] rd_data;
  logic        tick, hit, escaped, active;
  logic [1:0]  hit_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        shoot;
    logic [15:0] lane;
    logic        esc;
  } vec_t;

  vec_t vecs[21];

  projectile_grid #(
    .ROWS(8), .COLS(16), .TICK_DIV(4), .COOLDOWN(2), .HIT_W(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear), .shoot(shoot), .wrap(wrap),
    .player_row(player_row), .enemy_row(enemy_row), .enemy_col(enemy_col),
    .rd_row(rd_row), .rd_data(rd_data), .tick(tick), .hit(hit),
    .escaped(escaped), .hit_count(hit_count), .active(active)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Returns at the negedge inside the next tick cycle, or flags a timeout.
  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clock);
      if (tick) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got no tick expected tick within 16 cycles");
    end
  endtask

  initial begin
    logic [15:0] one;
    int n;
    one = 16'h0001;
    for (int i = 0; i < 16; i++) vecs[i] = '{(i == 0), one << i, 1'b0};
    vecs[16] = '{1'b0, 16'h0000, 1'b1};
    vecs[17] = '{1'b1, 16'h0001, 1'b0};
    vecs[18] = '{1'b1, 16'h0002, 1'b0};
    vecs[19] = '{1'b1, 16'h0004, 1'b0};
    vecs[20] = '{1'b1, 16'h0009, 1'b0};

    clear = 0; shoot = 0; wrap = 0; reset_n = 1;
    player_row = 3; enemy_row = 7; enemy_col = 15; rd_row = 3;

    #3 reset_n = 0;
    #9;
    chk("rst_tick", 32'(tick), 0);
    chk("rst_rd", 32'(rd_data), 0);
    chk("rst_cnt", 32'(hit_count), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_hit_esc", 32'({hit, escaped}), 0);
    @(negedge clock) reset_n = 1;

    // Tick spacing
    wait_tick();
    n = 0;
    do begin step(); n++; end while (!tick && n < 16);
    chk("tick_period", 32'(n), 4);
    chk("idle_rd", 32'(rd_data), 0);
    chk("idle_active", 32'(active), 0);

    // Flight, escape and cooldown table (lane 3, wrap off)
    foreach (vecs[i]) begin
      wait_tick();
      shoot = vecs[i].shoot;
      step();
      shoot = 0;
      chk($sformatf("vec%0d_esc", i), 32'(escaped), 32'(vecs[i].esc));
      step();
      chk($sformatf("vec%0d_lane", i), 32'(rd_data), 32'(vecs[i].lane));
    end

    // Synchronous clear
    enemy_row = 3; enemy_col = 5;
    clear = 1;
    step();
    clear = 0;
    step();
    chk("clear_rd", 32'(rd_data), 0);
    chk("clear_active", 32'(active), 0);

    // Shot meets enemy at (3,5) on the 6th tick
    wait_tick(); shoot = 1; step(); shoot = 0;
    for (int k = 2; k <= 6; k++) begin
      wait_tick();
      step();
      if (k < 6) chk($sformatf("pre_hit%0d", k), 32'(hit), 0);
    end
    chk("hit_pulse", 32'(hit), 1);
    chk("hit_cnt1", 32'(hit_count), 1);
    step();
    chk("hit_once", 32'(hit), 0);
    chk("hit_lane_empty", 32'(rd_data), 0);

    // Enemy steps onto a resting projectile between ticks
    enemy_col = 15;
    wait_tick(); shoot = 1; step(); shoot = 0;
    repeat (2) begin wait_tick(); step(); end
    enemy_col = 2;
    step();
    chk("move_hit", 32'(hit), 1);
    chk("hit_cnt2", 32'(hit_count), 2);
    step();
    chk("move_hit_once", 32'(hit), 0);

    // Load straight onto enemy at column 0; counter saturates at 3
    enemy_col = 0;
    wait_tick(); shoot = 1; step(); shoot = 0;
    chk("col0_hit", 32'(hit), 1);
    chk("hit_cnt3", 32'(hit_count), 3);
    repeat (2) begin wait_tick(); step(); end
    wait_tick(); shoot = 1; step(); shoot = 0;
    chk("sat_hit", 32'(hit), 1);
    chk("hit_cnt_sat", 32'(hit_count), 3);

    // Async reset mid-flight
    enemy_col = 15;
    repeat (2) begin wait_tick(); step(); end
    wait_tick(); shoot = 1; step(); shoot = 0;
    wait_tick(); step(); step();
    chk("flight_rd", 32'(rd_data), 32'h0002);
    chk("flight_active", 32'(active), 1);
    #2 reset_n = 0;
    #1;
    chk("arst_rd", 32'(rd_data), 0);
    chk("arst_cnt", 32'(hit_count), 0);
    chk("arst_active", 32'(active), 0);
    chk("arst_tick", 32'(tick), 0);
    @(negedge clock) reset_n = 1;

    // Wrap: lane 0 shot returns to column 0 after 16 ticks
    wrap = 1; player_row = 0; rd_row = 0; enemy_row = 7; enemy_col = 15;
    wait_tick(); shoot = 1; step(); shoot = 0;
    chk("wrap_esc0", 32'(escaped), 0);
    step();
    chk("wrap_load", 32'(rd_data), 32'h0001);
    for (int k = 1; k <= 16; k++) begin
      wait_tick();
      step();
      chk($sformatf("wrap_esc%0d", k), 32'(escaped), 0);
      step();
      if (k == 15) chk("wrap_col15", 32'(rd_data), 32'h8000);
      if (k == 16) chk("wrap_back", 32'(rd_data), 32'h0001);
    end

    // Clear in the tick cycle that would cause a hit at (0,1)
    enemy_row = 0; enemy_col = 1;
    wait_tick(); clear = 1; step(); clear = 0;
    chk("clr_tick_hit", 32'(hit), 0);
    chk("clr_tick_esc", 32'(escaped), 0);
    step();
    chk("clr_tick_rd", 32'(rd_data), 0);
    chk("clr_tick_active", 32'(active), 0);
    step();
    chk("clr_tick_hit_late", 32'(hit), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
